pipe_adder: RTL



---
 rtl/pipe_adder_if.sv | 26 ++
 rtl/pipe_adder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand side (in_*, a, b, sub) and result side (out_*, q, carry, ovf).
// master drives operands and consumes results; slave is the adder itself.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, q, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, q, carry, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES chunks, one register stage each.
// Optional PIPE_ADDER_SAT_EN: signed saturation of q in the final stage (default: q wraps).
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);
    localparam int CW = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_inv;

    // The whole pipe freezes, bubbles included, only while a finished result waits for the consumer.
    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;
    assign b_inv        = bus.b ^ {WIDTH{bus.sub}};

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO  = k * CW;
        localparam int REM = WIDTH - LO - CW;

        logic [CW-1:0]    op_a;
        logic [CW-1:0]    op_b;
        logic             cin;
        logic             vin;
        logic [CW:0]      chunk;
        logic [LO+CW-1:0] q_n;
        logic [LO+CW-1:0] q_r;
        logic             c_r;
        logic             v_r;

        if (k == 0) begin : g_head
            assign op_a = bus.a[CW-1:0];
            assign op_b = b_inv[CW-1:0];
            assign cin  = bus.sub;
            assign vin  = bus.in_valid;
            assign q_n  = chunk[CW-1:0];
        end else begin : g_body
            assign op_a = stg[k-1].g_up.a_r[CW-1:0];
            assign op_b = stg[k-1].g_up.b_r[CW-1:0];
            assign cin  = stg[k-1].c_r;
            assign vin  = stg[k-1].v_r;
            assign q_n  = {chunk[CW-1:0], stg[k-1].q_r};
        end

        assign chunk = {1'b0, op_a} + {1'b0, op_b} + {{CW{1'b0}}, cin};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
            end else if (adv) begin
                v_r <= vin;
            end
        end

        // Upper chunks still waiting for their turn travel down the pipe shifted to bit 0.
        if (REM > 0) begin : g_up
            logic [REM-1:0] a_r;
            logic [REM-1:0] b_r;
            logic [REM-1:0] a_src;
            logic [REM-1:0] b_src;

            if (k == 0) begin : g_src0
                assign a_src = bus.a[WIDTH-1:CW];
                assign b_src = b_inv[WIDTH-1:CW];
            end else begin : g_srcn
                assign a_src = stg[k-1].g_up.a_r[REM+CW-1:CW];
                assign b_src = stg[k-1].g_up.b_r[REM+CW-1:CW];
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_r <= a_src;
                    b_r <= b_src;
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            always_ff @(posedge clk) begin
                if (adv) begin
                    q_r <= q_n;
                    c_r <= chunk[CW];
                end
            end
        end else begin : g_last
            logic             msb_cin;
            logic             ovf_n;
            logic             ovf_r;
            logic [WIDTH-1:0] res;

            assign msb_cin = op_a[CW-1] ^ op_b[CW-1] ^ chunk[CW-1];
            assign ovf_n   = msb_cin ^ chunk[CW];

`ifdef PIPE_ADDER_SAT_EN
            // On overflow both operand MSBs agree, so the carry out equals the sign of the true result.
            always_comb begin
                res = q_n;
                if (ovf_n) begin
                    res = chunk[CW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign res = q_n;
`endif

            // Only real operations update the outputs, so bubbles never expose unreset data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r   <= '0;
                    c_r   <= 1'b0;
                    ovf_r <= 1'b0;
                end else if (adv && vin) begin
                    q_r   <= res;
                    c_r   <= chunk[CW];
                    ovf_r <= ovf_n;
                end
            end
        end
    end

    assign bus.out_valid = stg[STAGES-1].v_r;
    assign bus.q         = stg[STAGES-1].q_r;
    assign bus.carry     = stg[STAGES-1].c_r;
    assign bus.ovf       = stg[STAGES-1].g_last.ovf_r;
endmodule
